// File: rtl/cu_pkg.sv
// Shared encodings for the multi-cycle RV32 control unit: FSM states, datapath
// select codes, opcodes and the funct3 -> ALU operation mapping.
package cu_pkg;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StTrap   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        AluAdd   = 4'b0000,
        AluSub   = 4'b0001,
        AluXor   = 4'b0010,
        AluOr    = 4'b0011,
        AluAnd   = 4'b0100,
        AluSll   = 4'b0101,
        AluSrl   = 4'b0110,
        AluSra   = 4'b0111,
        AluSlt   = 4'b1000,
        AluSltu  = 4'b1001,
        AluPassB = 4'b1010,
        AluMul   = 4'b1011
    } alu_op_e;

    typedef enum logic [2:0] {
        ImmI  = 3'b000,
        ImmIu = 3'b001,
        ImmS  = 3'b010,
        ImmB  = 3'b011,
        ImmU  = 3'b100,
        ImmJ  = 3'b101
    } imm_src_e;

    typedef enum logic [1:0] {
        PcPlus4  = 2'b00,
        PcTarget = 2'b01,
        PcAlu    = 2'b10
    } pc_src_e;

    typedef enum logic [1:0] {
        ResAlu = 2'b00,
        ResMem = 2'b01,
        ResPc4 = 2'b10
    } result_src_e;

    typedef enum logic [2:0] {
        ClsAlu,
        ClsMul,
        ClsLoad,
        ClsStore,
        ClsBranch,
        ClsJal,
        ClsJalr
    } instr_class_e;

    localparam logic [1:0] CauseIllegal    = 2'b01;
    localparam logic [1:0] CauseMemTimeout = 2'b10;

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;

    // alt selects SUB/SRA over ADD/SRL (instr[30] where it is meaningful)
    function automatic logic [3:0] alu_from_funct3(logic [2:0] f3, logic alt);
        case (f3)
            3'b000:  return alt ? AluSub : AluAdd;
            3'b001:  return AluSll;
            3'b010:  return AluSlt;
            3'b011:  return AluSltu;
            3'b100:  return AluXor;
            3'b101:  return alt ? AluSra : AluSrl;
            3'b110:  return AluOr;
            default: return AluAnd;
        endcase
    endfunction

endpackage

// File: rtl/cu_decoder.sv
// Combinational instruction decoder: classifies the instruction word, produces
// the ALU/immediate/result selects and flags unsupported encodings.
module cu_decoder
    import cu_pkg::*;
#(
    parameter bit ENABLE_MUL = 1'b0
) (
    input  logic [31:0] instr_i,
    output logic [3:0]  alu_ctrl_o,
    output logic        alu_src_a_o,
    output logic        alu_src_b_o,
    output logic [2:0]  imm_src_o,
    output logic [1:0]  result_src_o,
    output logic [2:0]  instr_class_o,
    output logic        illegal_o
);
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_fields;

    assign opcode        = instr_i[6:0];
    assign funct3        = instr_i[14:12];
    assign funct7        = instr_i[31:25];
    assign unused_fields = ^{instr_i[24:15], instr_i[11:7]};

    always_comb begin
        alu_ctrl_o    = AluAdd;
        alu_src_a_o   = 1'b0;
        alu_src_b_o   = 1'b0;
        imm_src_o     = ImmI;
        result_src_o  = ResAlu;
        instr_class_o = ClsAlu;
        illegal_o     = 1'b0;
        case (opcode)
            OpcOp: begin
                if (funct7 == 7'b0000001) begin
                    instr_class_o = ClsMul;
                    alu_ctrl_o    = AluMul;
                    illegal_o     = !ENABLE_MUL || (funct3 != 3'b000);
                end else begin
                    alu_ctrl_o = alu_from_funct3(funct3, funct7[5]);
                    illegal_o  = !((funct7 == 7'b0000000) ||
                                   ((funct7 == 7'b0100000) &&
                                    ((funct3 == 3'b000) || (funct3 == 3'b101))));
                end
            end
            OpcOpImm: begin
                alu_src_b_o = 1'b1;
                // addi/xori/... have no alternate form; only srai uses instr[30]
                alu_ctrl_o  = alu_from_funct3(funct3, (funct3 == 3'b101) && funct7[5]);
                if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
                    imm_src_o = ImmIu;
                    illegal_o = !((funct7 == 7'b0000000) ||
                                  ((funct3 == 3'b101) && (funct7 == 7'b0100000)));
                end
            end
            OpcLoad: begin
                instr_class_o = ClsLoad;
                alu_src_b_o   = 1'b1;
                result_src_o  = ResMem;
                illegal_o     = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
            end
            OpcStore: begin
                instr_class_o = ClsStore;
                alu_src_b_o   = 1'b1;
                imm_src_o     = ImmS;
                illegal_o     = funct3[2] || (funct3 == 3'b011);
            end
            OpcBranch: begin
                instr_class_o = ClsBranch;
                alu_ctrl_o    = AluSub;
                imm_src_o     = ImmB;
                illegal_o     = (funct3[2:1] == 2'b01);
            end
            OpcJal: begin
                instr_class_o = ClsJal;
                imm_src_o     = ImmJ;
                result_src_o  = ResPc4;
            end
            OpcJalr: begin
                instr_class_o = ClsJalr;
                alu_src_b_o   = 1'b1;
                result_src_o  = ResPc4;
                illegal_o     = (funct3 != 3'b000);
            end
            OpcLui: begin
                alu_ctrl_o  = AluPassB;
                alu_src_b_o = 1'b1;
                imm_src_o   = ImmU;
            end
            OpcAuipc: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 1'b1;
                imm_src_o   = ImmU;
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle RV32I(+MUL) control FSM: sequences fetch/decode/exec/mem/writeback,
// tracks multi-cycle MUL latency and memory wait timeouts, and traps on faults.
module mc_control_unit
    import cu_pkg::*;
#(
    parameter bit          ENABLE_MUL  = 1'b0,
    parameter int unsigned MUL_CYCLES  = 4,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        less,
    input  logic        lessu,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_ifetch,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic [1:0]  pc_src,
    output logic        alu_src_a,
    output logic        alu_src_b,
    output logic [2:0]  imm_src,
    output logic [3:0]  alu_ctrl,
    output logic [1:0]  result_src,
    output logic [2:0]  funct3_o,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [2:0]  state_o
);
    state_e     state_q, state_d;
    logic [3:0] mul_cnt_q, mul_cnt_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic [1:0] cause_q, cause_d;

    logic [3:0] dec_alu_ctrl;
    logic       dec_src_a, dec_src_b, dec_illegal;
    logic [2:0] dec_imm_src, dec_class;
    logic [1:0] dec_result_src;
    logic       br_taken, mem_timeout;

    cu_decoder #(
        .ENABLE_MUL (ENABLE_MUL)
    ) u_decoder (
        .instr_i       (instr),
        .alu_ctrl_o    (dec_alu_ctrl),
        .alu_src_a_o   (dec_src_a),
        .alu_src_b_o   (dec_src_b),
        .imm_src_o     (dec_imm_src),
        .result_src_o  (dec_result_src),
        .instr_class_o (dec_class),
        .illegal_o     (dec_illegal)
    );

    assign funct3_o    = instr[14:12];
    assign state_o     = state_q;
    assign trap_cause  = cause_q;
    // Last permitted wait cycle: ready here still completes, silence traps.
    assign mem_timeout = (wait_cnt_q == 8'(MEM_TIMEOUT - 1));

    always_comb begin
        case (instr[14:12])
            3'b000:  br_taken = zero;
            3'b001:  br_taken = ~zero;
            3'b100:  br_taken = less;
            3'b101:  br_taken = ~less;
            3'b110:  br_taken = lessu;
            3'b111:  br_taken = ~lessu;
            default: br_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StFetch;
            mul_cnt_q  <= '0;
            wait_cnt_q <= '0;
            cause_q    <= 2'b00;
        end else begin
            state_q    <= state_d;
            mul_cnt_q  <= mul_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            cause_q    <= cause_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mul_cnt_d  = mul_cnt_q;
        wait_cnt_d = '0;
        cause_d    = cause_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_ifetch = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        pc_src     = PcPlus4;
        alu_src_a  = 1'b0;
        alu_src_b  = 1'b0;
        imm_src    = ImmI;
        alu_ctrl   = AluAdd;
        result_src = ResAlu;
        trap       = 1'b0;
        unique case (state_q)
            StFetch: begin
                mem_req    = 1'b1;
                mem_ifetch = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    state_d  = StDecode;
                end else if (mem_timeout) begin
                    state_d = StTrap;
                    cause_d = CauseMemTimeout;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            StDecode: begin
                mul_cnt_d = 4'(MUL_CYCLES - 1);
                if (dec_illegal) begin
                    state_d = StTrap;
                    cause_d = CauseIllegal;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                alu_ctrl  = dec_alu_ctrl;
                alu_src_a = dec_src_a;
                alu_src_b = dec_src_b;
                imm_src   = dec_imm_src;
                case (dec_class)
                    ClsMul: begin
                        if (mul_cnt_q == 4'd0) state_d = StWb;
                        else mul_cnt_d = mul_cnt_q - 4'd1;
                    end
                    ClsLoad, ClsStore: state_d = StMem;
                    ClsBranch: begin
                        pc_write = 1'b1;
                        pc_src   = br_taken ? PcTarget : PcPlus4;
                        state_d  = StFetch;
                    end
                    ClsJal: begin
                        pc_write = 1'b1;
                        pc_src   = PcTarget;
                        state_d  = StWb;
                    end
                    ClsJalr: begin
                        pc_write = 1'b1;
                        pc_src   = PcAlu;
                        state_d  = StWb;
                    end
                    default: state_d = StWb;
                endcase
            end
            StMem: begin
                mem_req = 1'b1;
                mem_we  = (dec_class == ClsStore);
                if (mem_ready) begin
                    if (dec_class == ClsStore) begin
                        pc_write = 1'b1;
                        state_d  = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end else if (mem_timeout) begin
                    state_d = StTrap;
                    cause_d = CauseMemTimeout;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            StWb: begin
                reg_write  = 1'b1;
                result_src = dec_result_src;
                // Jumps already wrote PC in EXEC.
                pc_write   = (dec_class != ClsJal) && (dec_class != ClsJalr);
                state_d    = StFetch;
            end
            StTrap: trap = 1'b1;
            default: state_d = StFetch;
        endcase
        if (!rst_n) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
            trap      = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: a vector table of single instructions plus
// hand sequences for memory waits, MUL latency, timeout and reset mid-access.
module tb_mc_control_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        zero = 1'b0, less = 1'b0, lessu = 1'b0, mem_ready = 1'b0;

    logic       a_mem_req, a_mem_we, a_mem_ifetch, a_ir_write, a_pc_write, a_reg_write;
    logic [1:0] a_pc_src, a_result_src, a_trap_cause;
    logic       a_alu_src_a, a_alu_src_b, a_trap;
    logic [2:0] a_imm_src, a_funct3, a_state;
    logic [3:0] a_alu_ctrl;

    logic       b_mem_req, b_mem_we, b_mem_ifetch, b_ir_write, b_pc_write, b_reg_write;
    logic [1:0] b_pc_src, b_result_src, b_trap_cause;
    logic       b_alu_src_a, b_alu_src_b, b_trap;
    logic [2:0] b_imm_src, b_funct3, b_state;
    logic [3:0] b_alu_ctrl;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    mc_control_unit #(
        .ENABLE_MUL  (1'b1),
        .MUL_CYCLES  (4),
        .MEM_TIMEOUT (15)
    ) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .zero       (zero),
        .less       (less),
        .lessu      (lessu),
        .mem_ready  (mem_ready),
        .mem_req    (a_mem_req),
        .mem_we     (a_mem_we),
        .mem_ifetch (a_mem_ifetch),
        .ir_write   (a_ir_write),
        .pc_write   (a_pc_write),
        .reg_write  (a_reg_write),
        .pc_src     (a_pc_src),
        .alu_src_a  (a_alu_src_a),
        .alu_src_b  (a_alu_src_b),
        .imm_src    (a_imm_src),
        .alu_ctrl   (a_alu_ctrl),
        .result_src (a_result_src),
        .funct3_o   (a_funct3),
        .trap       (a_trap),
        .trap_cause (a_trap_cause),
        .state_o    (a_state)
    );

    mc_control_unit #(
        .ENABLE_MUL  (1'b0),
        .MUL_CYCLES  (4),
        .MEM_TIMEOUT (3)
    ) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .zero       (zero),
        .less       (less),
        .lessu      (lessu),
        .mem_ready  (mem_ready),
        .mem_req    (b_mem_req),
        .mem_we     (b_mem_we),
        .mem_ifetch (b_mem_ifetch),
        .ir_write   (b_ir_write),
        .pc_write   (b_pc_write),
        .reg_write  (b_reg_write),
        .pc_src     (b_pc_src),
        .alu_src_a  (b_alu_src_a),
        .alu_src_b  (b_alu_src_b),
        .imm_src    (b_imm_src),
        .alu_ctrl   (b_alu_ctrl),
        .result_src (b_result_src),
        .funct3_o   (b_funct3),
        .trap       (b_trap),
        .trap_cause (b_trap_cause),
        .state_o    (b_state)
    );

    // -1 in an expected field means the value is not defined for that instruction
    typedef struct {
        logic [31:0] instr;
        logic [2:0]  flags;
        int st_exec, alu, a, b, imm, pcw, pcs, st_after, res, wb_pcw;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [31:0] i, input logic [2:0] f, input int se, input int alu,
                       input int a, input int b, input int imm, input int pcw, input int pcs,
                       input int sa, input int res, input int wbp);
        vec_t v;
        v.instr = i; v.flags = f; v.st_exec = se; v.alu = alu; v.a = a; v.b = b;
        v.imm = imm; v.pcw = pcw; v.pcs = pcs; v.st_after = sa; v.res = res; v.wb_pcw = wbp;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        if (exp < 0) return;
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    localparam logic [31:0] IAdd = 32'h002081B3;
    localparam logic [31:0] ILw  = 32'h0000A083;
    localparam logic [31:0] ISw  = 32'h0020A023;
    localparam logic [31:0] IMul = 32'h022081B3;

    initial begin
        vec_t v;
        //   instr         zlu     exe alu a   b   imm pcw pcs aft res wbp
        add(IAdd,          3'b000, 2,  0,  0,  0,  -1, 0,  -1, 4,  0,  1);
        add(32'h402081B3,  3'b000, 2,  1,  0,  0,  -1, 0,  -1, 4,  0,  1);
        add(32'h4020D1B3,  3'b000, 2,  7,  0,  0,  -1, 0,  -1, 4,  0,  1);
        add(32'h00500093,  3'b000, 2,  0,  0,  1,  0,  0,  -1, 4,  0,  1);
        add(32'h00309093,  3'b000, 2,  5,  0,  1,  1,  0,  -1, 4,  0,  1);
        add(32'h4030D093,  3'b000, 2,  7,  0,  1,  1,  0,  -1, 4,  0,  1);
        add(32'h123452B7,  3'b000, 2,  10, -1, 1,  4,  0,  -1, 4,  0,  1);
        add(32'h00001297,  3'b000, 2,  0,  1,  1,  4,  0,  -1, 4,  0,  1);
        add(32'h00208463,  3'b100, 2,  -1, -1, -1, 3,  1,  1,  0,  -1, -1);
        add(32'h00208463,  3'b000, 2,  -1, -1, -1, 3,  1,  0,  0,  -1, -1);
        add(32'h00209463,  3'b000, 2,  -1, -1, -1, 3,  1,  1,  0,  -1, -1);
        add(32'h0020E463,  3'b001, 2,  -1, -1, -1, 3,  1,  1,  0,  -1, -1);
        add(32'h0020D463,  3'b010, 2,  -1, -1, -1, 3,  1,  0,  0,  -1, -1);
        add(32'h010000EF,  3'b000, 2,  -1, -1, -1, 5,  1,  1,  4,  2,  0);
        add(32'h000100E7,  3'b000, 2,  0,  0,  1,  0,  1,  2,  4,  2,  0);
        add(ILw,           3'b000, 2,  0,  0,  1,  0,  0,  -1, 3,  -1, -1);
        add(32'h00000000,  3'b000, 5,  -1, -1, -1, -1, -1, -1, -1, -1, -1);
        add(32'h402091B3,  3'b000, 5,  -1, -1, -1, -1, -1, -1, -1, -1, -1);
        add(32'h40309093,  3'b000, 5,  -1, -1, -1, -1, -1, -1, -1, -1, -1);
        add(32'h0000B083,  3'b000, 5,  -1, -1, -1, -1, -1, -1, -1, -1, -1);
        add(32'h000110E7,  3'b000, 5,  -1, -1, -1, -1, -1, -1, -1, -1, -1);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_state", a_state, 0);
        chk("rst_mem_req", a_mem_req, 0);
        chk("rst_ir_write", a_ir_write, 0);
        chk("rst_trap", a_trap, 0);
        chk("rst_cause", a_trap_cause, 0);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_mem_req", a_mem_req, 1);
        chk("first_ifetch", a_mem_ifetch, 1);

        foreach (vq[i]) begin
            v = vq[i];
            do_reset();
            instr = v.instr;
            {zero, less, lessu} = v.flags;
            mem_ready = 1'b1;
            @(negedge clk);
            chk($sformatf("v%0d_fetch", i), a_state, 0);
            chk($sformatf("v%0d_ir_write", i), a_ir_write, 1);
            next_cycle();
            @(negedge clk);
            chk($sformatf("v%0d_decode", i), a_state, 1);
            next_cycle();
            @(negedge clk);
            chk($sformatf("v%0d_exec_state", i), a_state, v.st_exec);
            if (v.st_exec == 5) begin
                chk($sformatf("v%0d_trap", i), a_trap, 1);
                chk($sformatf("v%0d_cause", i), a_trap_cause, 1);
            end else begin
                chk($sformatf("v%0d_alu", i), a_alu_ctrl, v.alu);
                chk($sformatf("v%0d_src_a", i), a_alu_src_a, v.a);
                chk($sformatf("v%0d_src_b", i), a_alu_src_b, v.b);
                chk($sformatf("v%0d_imm", i), a_imm_src, v.imm);
                chk($sformatf("v%0d_pc_write", i), a_pc_write, v.pcw);
                if (v.pcw == 1) chk($sformatf("v%0d_pc_src", i), a_pc_src, v.pcs);
                chk($sformatf("v%0d_exec_regw", i), a_reg_write, 0);
                next_cycle();
                @(negedge clk);
                chk($sformatf("v%0d_after", i), a_state, v.st_after);
                if (v.st_after == 4) begin
                    chk($sformatf("v%0d_wb_regw", i), a_reg_write, 1);
                    chk($sformatf("v%0d_wb_pcw", i), a_pc_write, v.wb_pcw);
                    chk($sformatf("v%0d_wb_res", i), a_result_src, v.res);
                end
            end
        end

        // LW with ready delayed 3 cycles in MEM
        do_reset();
        instr = ILw;
        mem_ready = 1'b1;
        next_cycle();
        next_cycle();
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            @(negedge clk);
            chk($sformatf("lw_mem%0d_state", i), a_state, 3);
            chk($sformatf("lw_mem%0d_req", i), a_mem_req, 1);
            chk($sformatf("lw_mem%0d_we", i), a_mem_we, 0);
            chk($sformatf("lw_mem%0d_ifetch", i), a_mem_ifetch, 0);
            next_cycle();
        end
        @(negedge clk);
        chk("lw_wb_state", a_state, 4);
        chk("lw_wb_res", a_result_src, 1);
        chk("lw_wb_regw", a_reg_write, 1);

        // SW completes from MEM straight to FETCH
        do_reset();
        instr = ISw;
        mem_ready = 1'b1;
        next_cycle();
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("sw_mem_state", a_state, 3);
        chk("sw_mem_we", a_mem_we, 1);
        chk("sw_pc_write", a_pc_write, 1);
        chk("sw_pc_src", a_pc_src, 0);
        chk("sw_regw", a_reg_write, 0);
        next_cycle();
        @(negedge clk);
        chk("sw_next", a_state, 0);

        // MUL: 4 EXEC cycles on dut_a, illegal on dut_b
        do_reset();
        instr = IMul;
        mem_ready = 1'b1;
        next_cycle();
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("mul_exec%0d_state", i), a_state, 2);
            chk($sformatf("mul_exec%0d_alu", i), a_alu_ctrl, 11);
            if (i == 0) begin
                chk("mul_off_state", b_state, 5);
                chk("mul_off_trap", b_trap, 1);
                chk("mul_off_cause", b_trap_cause, 1);
                chk("mul_off_req", b_mem_req, 0);
            end
            next_cycle();
        end
        @(negedge clk);
        chk("mul_wb_state", a_state, 4);
        chk("mul_wb_regw", a_reg_write, 1);
        chk("trap_absorb_state", b_state, 5);
        chk("trap_absorb_regw", b_reg_write, 0);

        // Fetch timeout with MEM_TIMEOUT=3
        do_reset();
        instr = IAdd;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("to_wait%0d_state", i), b_state, 0);
            chk($sformatf("to_wait%0d_req", i), b_mem_req, 1);
            next_cycle();
        end
        @(negedge clk);
        chk("to_state", b_state, 5);
        chk("to_trap", b_trap, 1);
        chk("to_cause", b_trap_cause, 2);
        chk("to_req", b_mem_req, 0);

        // Ready on the last permitted cycle completes the fetch
        do_reset();
        for (int i = 0; i < 3; i++) begin
            mem_ready = (i == 2);
            @(negedge clk);
            chk($sformatf("late_wait%0d_state", i), b_state, 0);
            next_cycle();
        end
        @(negedge clk);
        chk("late_decode", b_state, 1);
        chk("late_trap", b_trap, 0);

        // Reset while a data request is outstanding
        do_reset();
        instr = ILw;
        mem_ready = 1'b1;
        next_cycle();
        next_cycle();
        next_cycle();
        mem_ready = 1'b0;
        @(negedge clk);
        chk("rmem_state", a_state, 3);
        chk("rmem_req", a_mem_req, 1);
        next_cycle();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rmem_req_in_rst", a_mem_req, 0);
        next_cycle();
        @(negedge clk);
        chk("rmem_state_after", a_state, 0);
        chk("rmem_trap", a_trap, 0);
        chk("rmem_req_low", a_mem_req, 0);
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rmem_req_back", a_mem_req, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mc_control_unit.md
MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 Parameter ENABLE_MUL, default 0; 1 SHALL decode RV32M MUL (funct7=0000001, funct3=000) as legal.
REQ-002 Parameter MUL_CYCLES, default 4, range 1..15; number of EXEC cycles a MUL SHALL occupy.
REQ-003 Parameter MEM_TIMEOUT, default 15, range 1..255; maximum wait cycles on any memory request before trap.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 instr  input  32  instruction word: fetch data while in FETCH, IR contents from DECODE onward.
REQ-007 zero, less, lessu  input  1 each  ALU flags for branch resolution.
REQ-008 mem_ready  input  1  memory handshake completion, shared by instruction and data requests.
REQ-009 mem_req, mem_we, mem_ifetch  output  1 each  memory request; write enable; 1 = instruction fetch.
REQ-010 ir_write, pc_write, reg_write  output  1 each  IR, PC and register-file write strobes.
REQ-011 pc_src  output  2  00 PC+4, 01 branch/JAL target, 10 ALU result (JALR, LSB cleared).
REQ-012 alu_src_a  output  1  0 rs1, 1 PC.
REQ-013 alu_src_b  output  1  0 rs2, 1 immediate.
REQ-014 imm_src  output  3  000 I, 001 I-unsigned/shamt, 010 S, 011 B, 100 U, 101 J.
REQ-015 alu_ctrl  output  4  0000 add, 0001 sub, 0010 xor, 0011 or, 0100 and, 0101 sll, 0110 srl, 0111 sra, 1000 slt, 1001 sltu, 1010 pass-B, 1011 mul.
REQ-016 result_src  output  2  00 ALU, 01 memory, 10 PC+4.
REQ-017 funct3_o  output  3  instr[14:12], passed through for load/store sizing.
REQ-018 trap, trap_cause  output  1, 2  trap flag; cause 01 illegal, 10 memory timeout.
REQ-019 state_o  output  3  current FSM state encoding.

Function
REQ-020 FSM states SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; transitions occur on rising clk only.
REQ-021 FETCH SHALL assert mem_req=1, mem_ifetch=1; on mem_ready SHALL pulse ir_write=1 for one cycle and go to DECODE.
REQ-022 DECODE SHALL go to TRAP with cause 01 for unsupported opcode, funct3 or funct7 (including MUL when ENABLE_MUL=0); otherwise go to EXEC.
REQ-023 EXEC R/I-type, LUI (pass-B, U-imm), AUIPC (add, src_a=PC): SHALL go to WB after one cycle.
REQ-024 EXEC MUL SHALL hold alu_ctrl=1011 for exactly MUL_CYCLES cycles, counted by an internal down-counter, then go to WB.
REQ-025 EXEC load/store SHALL compute address with add and go to MEM.
REQ-026 EXEC branch SHALL evaluate BEQ zero, BNE ~zero, BLT less, BGE ~less, BLTU lessu, BGEU ~lessu; pc_write=1 with pc_src=01 if taken, else 00; next state FETCH.
REQ-027 EXEC JAL/JALR SHALL pulse pc_write (pc_src 01/10) and go to WB with result_src=10.
REQ-028 MEM SHALL assert mem_req=1, mem_ifetch=0, mem_we=1 for store only; on mem_ready, load goes to WB (result_src=01) and store pulses pc_write (pc_src=00) and goes to FETCH.
REQ-029 WB SHALL pulse reg_write=1 for one cycle; for non-jump instructions it SHALL also pulse pc_write with pc_src=00; next state FETCH.
REQ-030 A wait counter SHALL clear on entry to FETCH or MEM, increment per cycle without mem_ready; reaching MEM_TIMEOUT SHALL enter TRAP with cause 10.
REQ-031 mem_ready arriving in the same cycle the counter reaches MEM_TIMEOUT SHALL complete the access, not trap.
REQ-032 mem_ready outside FETCH/MEM SHALL be ignored.
REQ-033 TRAP SHALL be absorbing until reset; trap=1, all write strobes and mem_req 0.
REQ-034 Writes to rd=x0 SHALL still assert reg_write; register file discards them.

Reset
REQ-035 rst_n=0 at a clock edge SHALL force FETCH, clear both counters, trap=0, trap_cause=00, regardless of state or outstanding request.
REQ-036 During reset all strobes and mem_req SHALL be 0; first mem_req SHALL appear the cycle after rst_n rises.

Structure
REQ-037 State enum, alu_ctrl, imm_src, pc_src, result_src encodings and opcode constants SHALL live in shared package cu_pkg.
REQ-038 Decode SHALL be a combinational sub-module cu_decoder (instr -> control fields, illegal flag); FSM and counters stay in mc_control_unit.

Verification
REQ-039 ADD x3,x1,x2 with mem_ready=1 -> states 0,1,2,4,0; alu_ctrl=0000; reg_write and pc_write pulse in WB; 4 cycles total.
REQ-040 BEQ with zero=1 -> pc_write=1, pc_src=01 in EXEC; zero=0 -> pc_src=00; no reg_write.
REQ-041 LW with mem_ready delayed 3 cycles in MEM -> MEM held 4 cycles, then WB with result_src=01.
REQ-042 ENABLE_MUL=1, MUL_CYCLES=4, MUL -> EXEC exactly 4 cycles, alu_ctrl=1011; ENABLE_MUL=0 -> TRAP, cause 01.
REQ-043 MEM_TIMEOUT=3, mem_ready held 0 in FETCH -> TRAP, cause 10 after 3 cycles; ready on 3rd cycle -> DECODE.
REQ-044 rst_n low during MEM with mem_req high -> next state FETCH, mem_req 0, trap 0.
